// File: rtl/ones_density_monitor.sv
// Two-stage pipelined population count for lane data, with a per-window ones total
// and low/high density flags latched each time a window of WINDOW valid words closes.
module ones_density_monitor #(
  parameter int WIDTH  = 64,
  parameter int WINDOW = 64,
  localparam int CW  = $clog2(WIDTH + 1),
  localparam int WSW = $clog2(WIDTH * WINDOW + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH-1:0] din,
  input  logic           din_valid,
  input  logic           clear,
  input  logic [WSW-1:0] thresh_lo,
  input  logic [WSW-1:0] thresh_hi,
  output logic [CW-1:0]  count,
  output logic           count_valid,
  output logic [WSW-1:0] win_sum,
  output logic           win_valid,
  output logic           win_low,
  output logic           win_high
);

  localparam int G   = (WIDTH + 5) / 6;
  localparam int PW  = G * 6;
  localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  function automatic logic [2:0] csa63(input logic [5:0] b);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) s = s + {2'b00, b[i]};
    return s;
  endfunction

  logic [PW-1:0]  din_pad;
  logic [2:0]     grp_p1 [G];
  logic           vld_p1;
  logic [CW-1:0]  tree_sum;
  logic [WSW-1:0] acc;
  logic [WSW-1:0] acc_next;
  logic [WCW-1:0] wcnt;
  logic           win_close;

  assign din_pad = PW'(din);

  // Stage 1: 6:3 compression of each zero-padded group
  always_ff @(posedge clk) begin
    for (int g = 0; g < G; g++) begin
      if (din_valid) grp_p1[g] <= csa63(din_pad[6*g +: 6]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= din_valid & ~clear;
  end

  // Stage 2: adder tree over the group sums; the total never exceeds WIDTH
  always_comb begin
    tree_sum = '0;
    for (int g = 0; g < G; g++) tree_sum = tree_sum + CW'(grp_p1[g]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= vld_p1 & ~clear;
      if (vld_p1 && !clear) count <= tree_sum;
    end
  end

  // Window accumulator: the closing word restarts acc/wcnt so back-to-back windows lose nothing
  assign acc_next  = acc + WSW'(count);
  assign win_close = count_valid && (wcnt == WCW'(WINDOW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      wcnt      <= '0;
      win_sum   <= '0;
      win_valid <= 1'b0;
      win_low   <= 1'b0;
      win_high  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (clear) begin
        acc  <= '0;
        wcnt <= '0;
      end else if (win_close) begin
        acc       <= '0;
        wcnt      <= '0;
        win_sum   <= acc_next;
        win_valid <= 1'b1;
        win_low   <= (acc_next < thresh_lo);
        win_high  <= (acc_next > thresh_hi);
      end else if (count_valid) begin
        acc  <= acc_next;
        wcnt <= wcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ones_density_monitor.sv
// Bench for ones_density_monitor: directed vector table and corner sequences on a
// 64-bit/4-word instance, then random traffic on it and a 12-bit/1-word instance.
module tb_ones_density_monitor;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_din;
  logic        a_v, a_clr;
  logic [8:0]  a_tlo, a_thi, a_ws;
  logic [6:0]  a_cnt;
  logic        a_cv, a_wv, a_lo, a_hi;

  logic [11:0] b_din;
  logic        b_v, b_clr;
  logic [3:0]  b_tlo, b_thi, b_ws, b_cnt;
  logic        b_cv, b_wv, b_lo, b_hi;

  ones_density_monitor #(.WIDTH(64), .WINDOW(4)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_v), .clear(a_clr),
    .thresh_lo(a_tlo), .thresh_hi(a_thi), .count(a_cnt), .count_valid(a_cv),
    .win_sum(a_ws), .win_valid(a_wv), .win_low(a_lo), .win_high(a_hi));

  ones_density_monitor #(.WIDTH(12), .WINDOW(1)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_v), .clear(b_clr),
    .thresh_lo(b_tlo), .thresh_hi(b_thi), .count(b_cnt), .count_valid(b_cv),
    .win_sum(b_ws), .win_valid(b_wv), .win_low(b_lo), .win_high(b_hi));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input bit cv, input int cnt, input bit wv,
                       input int ws, input bit lo, input bit hi);
    chk({tag, ".count_valid"}, a_cv, cv);
    chk({tag, ".count"}, a_cnt, cnt);
    chk({tag, ".win_valid"}, a_wv, wv);
    chk({tag, ".win_sum"}, a_ws, ws);
    chk({tag, ".win_low"}, a_lo, lo);
    chk({tag, ".win_high"}, a_hi, hi);
  endtask

  // One clock on DUT A: inputs applied after a falling edge, outputs seen at the next one
  task automatic cyc(input bit v, input logic [63:0] d, input bit c, input bit r);
    a_v = v; a_din = d; a_clr = c; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit v; logic [63:0] din; int tlo; int thi;
    bit cv; int cnt; bit wv; int ws; bit lo; bit hi;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input logic [63:0] d, input int tlo, input int thi,
                     input bit cv, input int cnt, input bit wv, input int ws,
                     input bit lo, input bit hi);
    tbl.push_back('{v:v, din:d, tlo:tlo, thi:thi, cv:cv, cnt:cnt, wv:wv, ws:ws, lo:lo, hi:hi});
  endtask

  // Four words of pattern w (ones set bits each) at thresholds 97/97, then idle until the window reports
  task automatic run_window(input string tag, input logic [63:0] w, input int ones);
    for (int k = 0; k < 8; k++) begin
      cyc(k < 4, w, 1'b0, 1'b0);
      chk($sformatf("%s%0d.count_valid", tag, k), a_cv, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk($sformatf("%s%0d.count", tag, k), a_cnt, ones);
      chk($sformatf("%s%0d.win_valid", tag, k), a_wv, (k == 5));
      if (k == 5) begin
        chk({tag, ".win_sum"}, a_ws, 4 * ones);
        chk({tag, ".win_low"}, a_lo, (4 * ones < 97));
        chk({tag, ".win_high"}, a_hi, (4 * ones > 97));
      end
    end
  endtask

  // Reference model: a word accepted at edge e shows its count after edge e+1; the WINDOW-th
  // accepted word of a window reports the window total after edge e+2. clear/rst drop anything unreported.
  typedef struct { int id; int due; int kind; int val; } ev_t;
  ev_t evq[$];
  int  edge_n = 0;
  int  wsum[2], wn[2];
  int  e_cv[2], e_cnt[2], e_wv[2], e_ws[2], e_lo[2], e_hi[2];

  task automatic purge(input int d);
    ev_t keep[$];
    foreach (evq[i]) if (evq[i].id != d) keep.push_back(evq[i]);
    evq = keep;
    wsum[d] = 0;
    wn[d] = 0;
  endtask

  task automatic model_edge(input int d, input int wnd, input bit v, input int ones,
                            input bit clr, input bit r, input int tlo, input int thi);
    ev_t keep[$];
    if (r) begin
      purge(d);
      e_cv[d] = 0; e_cnt[d] = 0; e_wv[d] = 0; e_ws[d] = 0; e_lo[d] = 0; e_hi[d] = 0;
      return;
    end
    e_cv[d] = 0;
    e_wv[d] = 0;
    if (clr) begin
      purge(d);
      return;
    end
    foreach (evq[i]) begin
      if (evq[i].id == d && evq[i].due == edge_n) begin
        if (evq[i].kind == 0) begin
          e_cv[d] = 1; e_cnt[d] = evq[i].val;
        end else begin
          e_wv[d] = 1; e_ws[d] = evq[i].val;
          e_lo[d] = int'(evq[i].val < tlo); e_hi[d] = int'(evq[i].val > thi);
        end
      end else keep.push_back(evq[i]);
    end
    evq = keep;
    if (v) begin
      evq.push_back('{id:d, due:edge_n + 1, kind:0, val:ones});
      wsum[d] += ones;
      wn[d]++;
      if (wn[d] == wnd) begin
        evq.push_back('{id:d, due:edge_n + 2, kind:1, val:wsum[d]});
        wsum[d] = 0;
        wn[d] = 0;
      end
    end
  endtask

  task automatic cmp_model(input int c);
    chk($sformatf("rnd%0d.a.count_valid", c), a_cv, e_cv[0]);
    if (e_cv[0] != 0) chk($sformatf("rnd%0d.a.count", c), a_cnt, e_cnt[0]);
    chk($sformatf("rnd%0d.a.win_valid", c), a_wv, e_wv[0]);
    chk($sformatf("rnd%0d.a.win_sum", c), a_ws, e_ws[0]);
    chk($sformatf("rnd%0d.a.win_low", c), a_lo, e_lo[0]);
    chk($sformatf("rnd%0d.a.win_high", c), a_hi, e_hi[0]);
    chk($sformatf("rnd%0d.b.count_valid", c), b_cv, e_cv[1]);
    if (e_cv[1] != 0) chk($sformatf("rnd%0d.b.count", c), b_cnt, e_cnt[1]);
    chk($sformatf("rnd%0d.b.win_valid", c), b_wv, e_wv[1]);
    chk($sformatf("rnd%0d.b.win_sum", c), b_ws, e_ws[1]);
    chk($sformatf("rnd%0d.b.win_low", c), b_lo, e_lo[1]);
    chk($sformatf("rnd%0d.b.win_high", c), b_hi, e_hi[1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_din = '0; a_v = 1'b0; a_clr = 1'b0; a_tlo = '0; a_thi = '0;
    b_din = '0; b_v = 1'b0; b_clr = 1'b0; b_tlo = '0; b_thi = '0;
    @(negedge clk);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk_a("reset", 0, 0, 0, 0, 0, 0);

    // Stream 64/0/32/1 at thresholds 100/96, then again at 97/97
    add(1, ONES, 100, 96, 0, 0, 0, 0, 0, 0);
    add(1, 64'h0, 100, 96, 1, 64, 0, 0, 0, 0);
    add(1, 64'h5555_5555_5555_5555, 100, 96, 1, 0, 0, 0, 0, 0);
    add(1, 64'h1, 100, 96, 1, 32, 0, 0, 0, 0);
    add(0, 64'h0, 100, 96, 1, 1, 0, 0, 0, 0);
    add(0, 64'h0, 100, 96, 0, 1, 1, 97, 1, 1);
    add(0, 64'h0, 100, 96, 0, 1, 0, 97, 1, 1);
    add(1, ONES, 97, 97, 0, 1, 0, 97, 1, 1);
    add(1, 64'h0, 97, 97, 1, 64, 0, 97, 1, 1);
    add(1, 64'h5555_5555_5555_5555, 97, 97, 1, 0, 0, 97, 1, 1);
    add(1, 64'h1, 97, 97, 1, 32, 0, 97, 1, 1);
    add(0, 64'h0, 97, 97, 1, 1, 0, 97, 1, 1);
    add(0, 64'h0, 97, 97, 0, 1, 1, 97, 0, 0);
    add(0, 64'h0, 97, 97, 0, 1, 0, 97, 0, 0);
    // Eight all-ones words with din_valid toggling: two windows of 256
    for (int j = 0; j < 18; j++)
      add((j % 2 == 0) && (j < 16), ONES, 97, 97, (j % 2 == 1) && (j <= 15),
          (j == 0) ? 1 : 64, (j == 8) || (j == 16), (j < 8) ? 97 : 256, 0, j >= 8);

    foreach (tbl[i]) begin
      a_tlo = 9'(tbl[i].tlo);
      a_thi = 9'(tbl[i].thi);
      cyc(tbl[i].v, tbl[i].din, 1'b0, 1'b0);
      chk_a($sformatf("tbl%0d", i), tbl[i].cv, tbl[i].cnt, tbl[i].wv, tbl[i].ws,
            tbl[i].lo, tbl[i].hi);
    end

    // clear together with the 4th word: in-flight words dropped, no pulse, count kept
    a_tlo = 9'd97; a_thi = 9'd97;
    cyc(1'b1, ONES, 1'b0, 1'b0);
    chk("clr0.count_valid", a_cv, 0);
    cyc(1'b1, 64'h0F, 1'b0, 1'b0);
    chk_a("clr1", 1, 64, 0, 256, 0, 1);
    cyc(1'b1, 64'hFF, 1'b0, 1'b0);
    chk_a("clr2", 1, 4, 0, 256, 0, 1);
    cyc(1'b1, ONES, 1'b1, 1'b0);
    chk_a("clr3", 0, 4, 0, 256, 0, 1);
    run_window("clrw", 64'h3, 2);

    // rst mid-window with a word in flight
    cyc(1'b1, 64'hFF, 1'b0, 1'b0);
    cyc(1'b1, 64'hFF, 1'b0, 1'b0);
    chk_a("pre_rst", 1, 8, 0, 8, 1, 0);
    cyc(1'b1, ONES, 1'b0, 1'b1);
    chk_a("rst0", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    chk_a("rst1", 0, 0, 0, 0, 0, 0);
    run_window("rstw", 64'h7, 3);

    // Random traffic on both instances against the model
    for (int c = 0; c < 500; c++) begin
      bit r;
      int mode;
      r = (c == 0) || ($urandom_range(0, 149) == 0);
      mode = $urandom_range(0, 7);
      a_v = ($urandom_range(0, 3) != 0);
      a_din = (mode == 0) ? ONES : (mode == 1) ? 64'h0 : {$urandom, $urandom};
      a_clr = ($urandom_range(0, 29) == 0);
      a_tlo = 9'($urandom_range(0, 300));
      a_thi = 9'($urandom_range(0, 300));
      b_v = ($urandom_range(0, 3) != 0);
      b_din = 12'($urandom);
      b_clr = ($urandom_range(0, 29) == 0);
      b_tlo = 4'($urandom_range(0, 15));
      b_thi = 4'($urandom_range(0, 15));
      rst = r;
      @(posedge clk);
      model_edge(0, 4, a_v, $countones(a_din), a_clr, r, int'(a_tlo), int'(a_thi));
      model_edge(1, 1, b_v, $countones(b_din), b_clr, r, int'(b_tlo), int'(b_thi));
      edge_n++;
      @(negedge clk);
      cmp_model(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
